phrase_reader: RTL and testbench

- Read-side master for the byte-wide phrase RAM (8-bit address, 1-cycle registered read, 8-bit q).
- On start, walks RAM from BASE_ADDR and fetches one byte per access.
- Emits each byte on a valid/ready character stream toward display/serial logic.
- Stops at a terminator byte or after MAX_LEN characters; never writes the RAM.

---
 rtl/phrase_reader.sv | 136 +++++++++++++
 tb/tb_phrase_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phrase_reader.sv
// phrase_reader: read-side master for the byte-wide phrase RAM.
// Walks RAM from BASE_ADDR and streams bytes out until TERM or MAX_LEN.
//
// Ports:
//   clock, rst_n       rising-edge clock, async active-low reset
//   start, abort       begin a phrase (IDLE only) / cancel a phrase
//   mem_address        RAM read address (driven from the pointer register)
//   mem_wren, mem_data RAM write side, tied to zero (read-only master)
//   mem_q              RAM read data, valid one cycle after the address
//   out_char/valid     character stream toward the consumer
//   out_ready          consumer accepts out_char
//   busy, done, count  status: not idle / completion pulse / chars accepted
//
// Optional feature (macro UPPER_CASE_EN): ASCII a..z are presented as A..Z.
// The terminator compare always uses the raw RAM byte.
module phrase_reader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_LEN   = 65,
    parameter logic [7:0]        TERM      = 8'h00
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [31:0]       mem_data,
    input  logic [7:0]        mem_q,
    output logic [7:0]        out_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [7:0]        count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_count;
    logic [7:0]        r_char;
    logic              r_valid;
    logic              r_done;

    logic [7:0]        w_char;
    logic              w_last;

    // Case folding happens at capture so out_char is a plain register.
`ifdef UPPER_CASE_EN
    assign w_char = (mem_q >= 8'h61 && mem_q <= 8'h7A) ?
                    (mem_q - 8'h20) : mem_q;
`else
    assign w_char = mem_q;
`endif

    assign w_last = ((r_count + 8'd1) == 8'(MAX_LEN));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= BASE_ADDR;
            r_count <= 8'd0;
            r_char  <= 8'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                // count and pointer are left as they were
                r_state <= S_IDLE;
                r_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_ptr   <= BASE_ADDR;
                            r_count <= 8'd0;
                            r_state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_char <= w_char;
                        if (mem_q == TERM) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_OUT;
                            r_valid <= 1'b1;
                        end
                    end
                    S_OUT: begin
                        if (out_ready) begin
                            r_valid <= 1'b0;
                            r_count <= r_count + 8'd1;
                            r_ptr   <= r_ptr + 1'b1;
                            if (w_last) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_address = r_ptr;
    assign mem_wren    = 1'b0;
    assign mem_data    = 32'd0;
    assign out_char    = r_char;
    assign out_valid   = r_valid;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign count       = r_count;

endmodule

// File: tb/tb_phrase_reader.sv
// tb_phrase_reader: directed bench for phrase_reader.
// Two instances: BASE_ADDR=0 (main tests) and BASE_ADDR=FE (wrap test).
module tb_phrase_reader;

    logic        clock;
    logic        rst_n;
    logic        sel;
    logic        start;
    logic        abort;
    logic        ready;

    logic        start0, abort0, ready0;
    logic        start1, abort1, ready1;
    logic [7:0]  addr0, addr1;
    logic        wren0, wren1;
    logic [31:0] data0, data1;
    logic [7:0]  q0, q1;
    logic [7:0]  char0, char1;
    logic        valid0, valid1;
    logic        busy0, busy1;
    logic        done0, done1;
    logic [7:0]  count0, count1;

    logic [7:0]  ram0 [256];
    logic [7:0]  ram1 [256];

    logic [7:0]  addr_m, char_m, count_m;
    logic        valid_m, busy_m, done_m;

    int          checks;
    int          errors;

    logic [7:0]  got_c [256];
    logic [7:0]  got_a [256];
    int          got_cyc [256];
    int          n_got;
    int          done_cyc;
    logic [7:0]  done_cnt;
    logic [7:0]  done_addr;
    logic        timeout;

    typedef struct {
        logic [0:3][7:0] ram;
        int              stall;
        int              n;
        logic [0:2][7:0] e;
        int              first;
        int              dcyc;
    } vec_t;

    vec_t vec [4];

    assign start0 = start & ~sel;
    assign abort0 = abort & ~sel;
    assign ready0 = ready & ~sel;
    assign start1 = start & sel;
    assign abort1 = abort & sel;
    assign ready1 = ready & sel;

    assign addr_m  = sel ? addr1  : addr0;
    assign char_m  = sel ? char1  : char0;
    assign count_m = sel ? count1 : count0;
    assign valid_m = sel ? valid1 : valid0;
    assign busy_m  = sel ? busy1  : busy0;
    assign done_m  = sel ? done1  : done0;

    phrase_reader #(
        .ADDR_W(8), .BASE_ADDR(8'h00), .MAX_LEN(65), .TERM(8'h00)
    ) u_dut0 (
        .clock(clock), .rst_n(rst_n), .start(start0), .abort(abort0),
        .mem_address(addr0), .mem_wren(wren0), .mem_data(data0),
        .mem_q(q0), .out_char(char0), .out_valid(valid0),
        .out_ready(ready0), .busy(busy0), .done(done0), .count(count0)
    );

    phrase_reader #(
        .ADDR_W(8), .BASE_ADDR(8'hFE), .MAX_LEN(65), .TERM(8'h00)
    ) u_dut1 (
        .clock(clock), .rst_n(rst_n), .start(start1), .abort(abort1),
        .mem_address(addr1), .mem_wren(wren1), .mem_data(data1),
        .mem_q(q1), .out_char(char1), .out_valid(valid1),
        .out_ready(ready1), .busy(busy1), .done(done1), .count(count1)
    );

    always @(posedge clock) begin
        q0 <= ram0[addr0];
        q1 <= ram1[addr1];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle 0 is the cycle start is high; inputs change on negedges.
    task automatic run(input int stall, input logic [7:0] stall_exp,
                       input int abort_n);
        int stall_left;
        logic fin;
        n_got      = 0;
        done_cyc   = -1;
        done_cnt   = 8'hxx;
        done_addr  = 8'hxx;
        timeout    = 1'b0;
        fin        = 1'b0;
        stall_left = stall;
        @(negedge clock);
        start = 1'b1;
        ready = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 400 && !fin; c++) begin
            @(negedge clock);
            start = 1'b0;
            abort = 1'b0;
            ready = 1'b0;
            if (done_m) begin
                done_cyc  = c;
                done_cnt  = count_m;
                done_addr = addr_m;
                fin       = 1'b1;
            end else if (valid_m) begin
                if (abort_n == n_got) begin
                    abort = 1'b1;
                    ready = 1'b1;
                    fin   = 1'b1;
                end else if (stall_left > 0) begin
                    stall_left--;
                    check("stall_char", char_m, stall_exp);
                end else begin
                    ready          = 1'b1;
                    got_c[n_got]   = char_m;
                    got_a[n_got]   = addr_m;
                    got_cyc[n_got] = c;
                    n_got++;
                end
            end
        end
        if (!fin) begin
            timeout = 1'b1;
            start = 1'b0;
            ready = 1'b0;
        end
        check("no_timeout", timeout, 0);
    endtask

    initial begin
        int bad;
        int dn;
        checks = 0;
        errors = 0;
        sel    = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        ready  = 1'b0;
        rst_n  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram0[i] = 8'h00;
            ram1[i] = 8'h00;
        end

        vec[0] = '{ram: {8'h48, 8'h49, 8'h21, 8'h00}, stall: 0, n: 3,
                   e: {8'h48, 8'h49, 8'h21}, first: 3, dcyc: 12};
        vec[1] = '{ram: {8'h48, 8'h49, 8'h21, 8'h00}, stall: 5, n: 3,
                   e: {8'h48, 8'h49, 8'h21}, first: 8, dcyc: 17};
        vec[2] = '{ram: {8'h00, 8'h41, 8'h42, 8'h00}, stall: 0, n: 0,
                   e: {8'h00, 8'h00, 8'h00}, first: 3, dcyc: 3};
`ifdef UPPER_CASE_EN
        vec[3] = '{ram: {8'h61, 8'h62, 8'h7B, 8'h00}, stall: 0, n: 3,
                   e: {8'h41, 8'h42, 8'h7B}, first: 3, dcyc: 12};
`else
        vec[3] = '{ram: {8'h61, 8'h62, 8'h7B, 8'h00}, stall: 0, n: 3,
                   e: {8'h61, 8'h62, 8'h7B}, first: 3, dcyc: 12};
`endif

        // reset values
        #12;
        check("rst_valid", valid0, 0);
        check("rst_done", done0, 0);
        check("rst_busy", busy0, 0);
        check("rst_char", char0, 8'h00);
        check("rst_count", count0, 8'h00);
        check("rst_addr0", addr0, 8'h00);
        check("rst_addr1", addr1, 8'hFE);
        check("rst_wren", {wren0, wren1}, 0);
        check("rst_data", data0 | data1, 0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        // table-driven phrases on instance 0
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) ram0[i] = vec[v].ram[i];
            run(vec[v].stall, vec[v].e[0], -1);
            check($sformatf("v%0d_n", v), n_got, vec[v].n);
            for (int k = 0; k < vec[v].n && k < n_got; k++) begin
                check($sformatf("v%0d_char%0d", v, k),
                      got_c[k], vec[v].e[k]);
                check($sformatf("v%0d_cyc%0d", v, k),
                      got_cyc[k], vec[v].first + 3 * k);
            end
            check($sformatf("v%0d_done_cyc", v), done_cyc, vec[v].dcyc);
            check($sformatf("v%0d_count", v), done_cnt, vec[v].n);
            @(negedge clock);
            check($sformatf("v%0d_done_pulse", v), done_m, 0);
            check($sformatf("v%0d_idle", v), busy_m, 0);
            check($sformatf("v%0d_count_hold", v), count_m, vec[v].n);
        end

        // MAX_LEN limit: 65 of 256 nonzero bytes
        for (int i = 0; i < 256; i++) ram0[i] = 8'h21 + 8'(i % 90);
        run(0, 8'h00, -1);
        check("max_n", n_got, 65);
        bad = 0;
        for (int k = 0; k < n_got; k++)
            if (got_c[k] !== ram0[k]) bad++;
        check("max_data", bad, 0);
        check("max_last_addr", got_a[64], 8'd64);
        check("max_done_cyc", done_cyc, 196);
        check("max_count", done_cnt, 8'd65);

        // pointer wrap on instance 1
        sel = 1'b1;
        ram1[8'hFE] = 8'h41;
        ram1[8'hFF] = 8'h42;
        ram1[8'h00] = 8'h00;
        @(negedge clock);
        run(0, 8'h00, -1);
        check("wrap_n", n_got, 2);
        check("wrap_c0", got_c[0], 8'h41);
        check("wrap_c1", got_c[1], 8'h42);
        check("wrap_a0", got_a[0], 8'hFE);
        check("wrap_a1", got_a[1], 8'hFF);
        check("wrap_done_addr", done_addr, 8'h00);
        check("wrap_done_cyc", done_cyc, 9);
        check("wrap_count", done_cnt, 8'd2);
        sel = 1'b0;

        // abort during the second character's OUT cycle
        for (int i = 0; i < 4; i++) ram0[i] = vec[0].ram[i];
        @(negedge clock);
        run(0, 8'h00, 1);
        check("abort_n", n_got, 1);
        check("abort_c0", got_c[0], 8'h48);
        @(negedge clock);
        abort = 1'b0;
        ready = 1'b0;
        check("abort_valid", valid0, 0);
        check("abort_busy", busy0, 0);
        check("abort_count", count0, 8'd1);
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            if (done0) dn++;
            @(negedge clock);
        end
        check("abort_no_done", dn, 0);
        check("abort_count_hold", count0, 8'd1);

        // restart after abort rereads from BASE_ADDR
        run(0, 8'h00, -1);
        check("restart_n", n_got, 3);
        check("restart_c0", got_c[0], 8'h48);
        check("restart_a0", got_a[0], 8'h00);
        check("restart_count", done_cnt, 8'd3);

        // reset mid-phrase
        run(0, 8'h00, 0);
        abort = 1'b0;
        ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", valid0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_count", count0, 8'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
